// File: rtl/qpsk_sym_ctrl_if.sv
// Bit-stream input and symbol/phase output bundle for qpsk_sym_ctrl.
// The slave modport is the controller; the master side feeds bits and watches symbols.
interface qpsk_sym_ctrl_if #(
  parameter int PHASE_W = 4
);
  logic               bit_in;
  logic               bit_valid;
  logic               bit_ready;
  logic [1:0]         sym;
  logic               sym_valid;
  logic [PHASE_W-1:0] phase;
  logic               sym_load;

  modport master (
    output bit_in, bit_valid,
    input  bit_ready, sym, sym_valid, phase, sym_load
  );

  modport slave (
    input  bit_in, bit_valid,
    output bit_ready, sym, sym_valid, phase, sym_load
  );
endinterface

// File: rtl/qpsk_sym_ctrl.sv
// QPSK symbol controller: pairs serial bits into dibits and paces them out one per carrier period.
// Optional macro QPSK_GRAY_EN applies Gray mapping to each loaded symbol.
module qpsk_sym_ctrl #(
  parameter int CARRIER_LEN = 16,
  parameter int PHASE_W     = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  qpsk_sym_ctrl_if.slave sym_if,
  output logic           underrun,
  output logic           busy
);

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CARRIER_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN,
    ST_STOP
  } state_e;

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [1:0]         sym_q, sym_d;
  logic               sym_valid_q, sym_valid_d;
  logic               sym_load_q, sym_load_d;
  logic               underrun_q, underrun_d;

  logic               low_bit_q, low_bit_d;
  logic               have_low_q, have_low_d;
  logic [1:0]         pend_q, pend_d;
  logic               pend_valid_q, pend_valid_d;

  logic               bit_ready;
  logic               bit_xfer;
  logic               at_last;
  logic [PHASE_W-1:0] phase_next;
  logic               load;

  function automatic logic [1:0] map_dibit(input logic [1:0] dibit);
`ifdef QPSK_GRAY_EN
    return {dibit[1], dibit[1] ^ dibit[0]};
`else
    return dibit;
`endif
  endfunction

  // Three bits held (full dibit plus a low bit) is the only state with no room.
  assign bit_ready  = ~(pend_valid_q & have_low_q);
  assign bit_xfer   = sym_if.bit_valid & bit_ready;
  assign at_last    = (phase_q == PHASE_LAST);
  assign phase_next = at_last ? '0 : phase_q + PHASE_W'(1);

  // Bit assembly. A load and a low-bit capture may coincide; a full dibit never
  // arrives while one is still pending because bit_ready blocks that case.
  // NOTE: every always_comb target gets its default first so no path can infer a latch.
  always_comb begin
    low_bit_d    = low_bit_q;
    have_low_d   = have_low_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q & ~load;
    if (bit_xfer) begin
      if (have_low_q) begin
        pend_d       = {sym_if.bit_in, low_bit_q};
        pend_valid_d = 1'b1;
        have_low_d   = 1'b0;
      end else begin
        low_bit_d  = sym_if.bit_in;
        have_low_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    sym_valid_d = sym_valid_q;
    underrun_d  = underrun_q;
    load        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        phase_d     = '0;
        sym_valid_d = 1'b0;
        if (en) state_d = ST_PRIME;
      end

      ST_PRIME: begin
        phase_d     = '0;
        sym_valid_d = 1'b0;
        if (!en) begin
          state_d = ST_IDLE;
        end else if (pend_valid_q) begin
          load        = 1'b1;
          sym_valid_d = 1'b1;
          state_d     = ST_RUN;
        end
      end

      ST_RUN: begin
        phase_d = phase_next;
        if (!en) begin
          // Losing enable exactly on the last phase means the symbol is already complete.
          if (at_last) begin
            sym_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_STOP;
          end
        end else if (at_last) begin
          if (pend_valid_q) begin
            load = 1'b1;
          end else begin
            underrun_d  = 1'b1;
            sym_valid_d = 1'b0;
            state_d     = ST_PRIME;
          end
        end
      end

      ST_STOP: begin
        phase_d = phase_next;
        if (at_last) begin
          sym_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        phase_d     = '0;
        sym_valid_d = 1'b0;
      end
    endcase
  end

  // The strobe is registered alongside sym so it marks the first cycle of the new symbol.
  assign sym_load_d = load;
  assign sym_d      = load ? map_dibit(pend_q) : sym_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      sym_q        <= 2'b00;
      sym_valid_q  <= 1'b0;
      sym_load_q   <= 1'b0;
      underrun_q   <= 1'b0;
      low_bit_q    <= 1'b0;
      have_low_q   <= 1'b0;
      pend_q       <= 2'b00;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      sym_q        <= sym_d;
      sym_valid_q  <= sym_valid_d;
      sym_load_q   <= sym_load_d;
      underrun_q   <= underrun_d;
      low_bit_q    <= low_bit_d;
      have_low_q   <= have_low_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign sym_if.bit_ready = bit_ready;
  assign sym_if.sym       = sym_q;
  assign sym_if.sym_valid = sym_valid_q;
  assign sym_if.phase     = phase_q;
  assign sym_if.sym_load  = sym_load_q;
  assign underrun         = underrun_q;
  assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_qpsk_sym_ctrl.sv
// Self-checking bench for qpsk_sym_ctrl: directed scenarios plus random traffic,
// compared every cycle against a bit-queue reference model of the controller.
module tb_qpsk_sym_ctrl;

  localparam int CARRIER_LEN = 16;
  localparam int PHASE_W     = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic underrun;
  logic busy;

  qpsk_sym_ctrl_if #(.PHASE_W(PHASE_W)) sif ();

  qpsk_sym_ctrl #(
    .CARRIER_LEN(CARRIER_LEN),
    .PHASE_W    (PHASE_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .sym_if  (sif.slave),
    .underrun(underrun),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef enum {M_IDLE, M_PRIME, M_RUN, M_STOP} mode_e;

  // Reference model: the held bits are a plain queue, the symbol is a phase counter.
  mode_e      m_mode;
  int         m_phase;
  logic [1:0] m_sym;
  bit         m_sym_valid;
  bit         m_sym_load;
  bit         m_underrun;
  bit         m_q[$];

  int         load_cyc[$];
  logic [1:0] load_sym[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [1:0] exp_map(input logic [1:0] d);
`ifdef QPSK_GRAY_EN
    case (d)
      2'b00:   return 2'b00;
      2'b01:   return 2'b01;
      2'b11:   return 2'b10;
      default: return 2'b11;
    endcase
`else
    return d;
`endif
  endfunction

  task automatic model_reset();
    m_mode      = M_IDLE;
    m_phase     = 0;
    m_sym       = 2'b00;
    m_sym_valid = 1'b0;
    m_sym_load  = 1'b0;
    m_underrun  = 1'b0;
    m_q.delete();
  endtask

  task automatic model_step(input bit en_v, input bit acc, input bit b);
    bit    do_load;
    bit    last;
    bit    have_dibit;
    mode_e nmode;
    int    nphase;
    bit    nvalid;
    do_load    = 1'b0;
    last       = (m_phase == CARRIER_LEN - 1);
    have_dibit = (m_q.size() >= 2);
    nmode      = m_mode;
    nphase     = (m_mode == M_RUN || m_mode == M_STOP) ? (m_phase + 1) % CARRIER_LEN : 0;
    nvalid     = m_sym_valid;
    case (m_mode)
      M_IDLE: begin
        nvalid = 1'b0;
        if (en_v) nmode = M_PRIME;
      end
      M_PRIME: begin
        nvalid = 1'b0;
        if (!en_v) nmode = M_IDLE;
        else if (have_dibit) begin
          do_load = 1'b1;
          nvalid  = 1'b1;
          nmode   = M_RUN;
        end
      end
      M_RUN: begin
        if (!en_v) begin
          if (last) begin
            nmode  = M_IDLE;
            nvalid = 1'b0;
          end else nmode = M_STOP;
        end else if (last) begin
          if (have_dibit) do_load = 1'b1;
          else begin
            m_underrun = 1'b1;
            nvalid     = 1'b0;
            nmode      = M_PRIME;
          end
        end
      end
      M_STOP: begin
        if (last) begin
          nmode  = M_IDLE;
          nvalid = 1'b0;
        end
      end
      default: nmode = M_IDLE;
    endcase
    if (do_load) begin
      m_sym = exp_map({m_q[1], m_q[0]});
      void'(m_q.pop_front());
      void'(m_q.pop_front());
    end
    if (acc) m_q.push_back(b);
    m_sym_load  = do_load;
    m_mode      = nmode;
    m_phase     = nphase;
    m_sym_valid = nvalid;
  endtask

  task automatic compare_all();
    check("phase",     32'(sif.phase),     32'(m_phase));
    check("sym",       32'(sif.sym),       32'(m_sym));
    check("sym_valid", 32'(sif.sym_valid), 32'(m_sym_valid));
    check("sym_load",  32'(sif.sym_load),  32'(m_sym_load));
    check("underrun",  32'(underrun),      32'(m_underrun));
    check("busy",      32'(busy),          32'(m_mode != M_IDLE));
    check("bit_ready", 32'(sif.bit_ready), 32'(m_q.size() < 3));
  endtask

  // One clock: compare at the negedge, drive inputs, advance the model, step to next negedge.
  task automatic cycle(input bit en_v, input bit valid_v, input bit b);
    bit acc;
    compare_all();
    if (sif.sym_load === 1'b1) begin
      load_cyc.push_back(cyc);
      load_sym.push_back(sif.sym);
    end
    en            = en_v;
    sif.bit_valid = valid_v;
    sif.bit_in    = b;
    acc           = valid_v && (m_q.size() < 3);
    model_step(en_v, acc, b);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Reset is asserted right at a negedge and checked 1 time unit later, before any clock edge.
  task automatic do_reset();
    rst_n         = 1'b0;
    en            = 1'b0;
    sif.bit_valid = 1'b0;
    sif.bit_in    = 1'b0;
    #1;
    check("rst_phase",     32'(sif.phase),     32'd0);
    check("rst_sym",       32'(sif.sym),       32'd0);
    check("rst_sym_valid", 32'(sif.sym_valid), 32'd0);
    check("rst_sym_load",  32'(sif.sym_load),  32'd0);
    check("rst_underrun",  32'(underrun),      32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_bit_ready", 32'(sif.bit_ready), 32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_pairs_then_idle(input bit b0, input bit b1, input bit b2, input bit b3);
    load_cyc.delete();
    load_sym.delete();
    cycle(1'b1, 1'b1, b0);
    cycle(1'b1, 1'b1, b1);
    cycle(1'b1, 1'b1, b2);
    cycle(1'b1, 1'b1, b3);
    repeat (40) cycle(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    bit reached;
    int density;
    sif.bit_in    = 1'b0;
    sif.bit_valid = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Back-to-back symbols: 01 loaded from PRIME, 11 exactly one carrier period later.
    send_pairs_then_idle(1'b1, 1'b0, 1'b1, 1'b1);
    check("b2b_loads", 32'(load_cyc.size() >= 2), 32'd1);
    if (load_cyc.size() >= 2) begin
      check("b2b_gap",  32'(load_cyc[1] - load_cyc[0]), 32'(CARRIER_LEN));
      check("b2b_sym0", 32'(load_sym[0]), 32'(exp_map(2'b01)));
      check("b2b_sym1", 32'(load_sym[1]), 32'(exp_map(2'b11)));
    end
    // The source stalled after the second dibit, so the boundary must have underrun.
    check("underrun_set", 32'(underrun), 32'd1);
    check("underrun_phase0", 32'(sif.phase), 32'd0);

    // Dibits 10 then 11 (Gray build maps them to 11 then 10).
    do_reset();
    send_pairs_then_idle(1'b0, 1'b1, 1'b1, 1'b1);
    if (load_cyc.size() >= 2) begin
      check("map_sym0", 32'(load_sym[0]), 32'(exp_map(2'b10)));
      check("map_sym1", 32'(load_sym[1]), 32'(exp_map(2'b11)));
    end else begin
      check("map_loads", 32'(load_cyc.size()), 32'd2);
    end

    // Continuous bit_valid: backpressure and recovery are checked each cycle by the model.
    do_reset();
    repeat (70) cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)));

    // Reset in the middle of a symbol at phase 7.
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)));
      reached = (m_mode == M_RUN && m_phase == 7);
    end
    check("reach_phase7", 32'(reached), 32'd1);
    check("pre_rst_phase", 32'(sif.phase), 32'd7);
    do_reset();

    // Drop enable at phase 5: symbol finishes, then idle.
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)));
      reached = (m_mode == M_RUN && m_phase == 5);
    end
    check("reach_phase5", 32'(reached), 32'd1);
    for (int i = 0; i < 40 && m_mode != M_IDLE; i++)
      cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    check("stop_idle", 32'(m_mode == M_IDLE), 32'd1);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_sym_valid", 32'(sif.sym_valid), 32'd0);

    // Random traffic with slowly changing bit density and occasional enable toggles.
    do_reset();
    begin
      bit en_r;
      en_r    = 1'b1;
      density = 50;
      for (int i = 0; i < 3000; i++) begin
        if (i % 200 == 0) density = int'($urandom_range(5, 100));
        if ($urandom_range(0, 99) < 2) en_r = ~en_r;
        cycle(en_r, 1'($urandom_range(0, 99) < density), 1'($urandom_range(0, 1)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
